// File: rtl/router_buffer_fifo.sv
// Synchronous FIFO feeding one input port of the 3-input router merge (or buffering its output).
// Optional sticky overflow/underflow flags: define ROUTER_FIFO_ERR_FLAGS_EN.
module router_buffer_fifo #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wen,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  do_write;
  logic                  do_read;

  // Requests are qualified by the registered flags, so a write into a full
  // FIFO is dropped even when a read frees a slot on the same edge.
  assign do_write = wen && !full;
  assign do_read  = read_en && !empty;

  always_comb begin
    count_next = count;
    case ({do_write, do_read})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // NOTE: storage has no reset so it can map onto RAM; resetting the pointers
  // and count already makes any stale contents unreachable.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= din;
  end

  // NOTE: non-blocking assignments mean a read at wr_ptr == rd_ptr returns the
  // entry stored before this edge, never the din being written now.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_read) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == FULL_COUNT);
    end
  end

`ifdef ROUTER_FIFO_ERR_FLAGS_EN
  // Sticky until reset: only rst clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wen && full)      overflow  <= 1'b1;
      if (read_en && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_router_buffer_fifo.sv
// Self-checking bench for router_buffer_fifo: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations and a randomized phase.
module tb_router_buffer_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          wen;
  logic          read_en;
  logic [DW-1:0] dout;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  router_buffer_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .wen      (wen),
    .read_en  (read_en),
    .dout     (dout),
    .empty    (empty),
    .full     (full),
    .count    (count)
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored packets plus the last value read out.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  logic          m_ovf  = 1'b0;
  logic          m_unf  = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      automatic int  sz = q.size();
      automatic bit  w  = wen && (sz != DEPTH);
      automatic bit  r  = read_en && (sz != 0);
      if (wen && sz == DEPTH) m_ovf = 1'b1;
      if (read_en && sz == 0) m_unf = 1'b1;
      if (r) m_dout = q.pop_front();
      if (w) q.push_back(din);
    end
    #1;
    check("model_dout",  64'(dout),  64'(m_dout));
    check("model_count", 64'(count), 64'(q.size()));
    check("model_empty", 64'(empty), 64'(q.size() == 0));
    check("model_full",  64'(full),  64'(q.size() == DEPTH));
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
    check("model_overflow",  64'(overflow),  64'(m_ovf));
    check("model_underflow", 64'(underflow), 64'(m_unf));
`endif
  end

  // Called at a negedge: drive for one posedge, return at the next negedge.
  task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d);
    wen = w; read_en = r; din = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; wen = 1'b0; read_en = 1'b0; din = '0;

    // 1. Reset with random write activity
    @(negedge clk);
    for (int i = 0; i < 4; i++) cyc(1'($urandom), 1'($urandom), $urandom);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full",  64'(full),  64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_dout",  64'(dout),  64'd0);
    rst = 1'b1;
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, '0);
    check("post_rst_empty", 64'(empty), 64'd1);
    check("post_rst_dout",  64'(dout),  64'd0);

    // 2. Fill / drain
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, DW'(32'hA0 + i));
    check("fill_full",  64'(full),  64'd1);
    check("fill_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, '0);
      check("drain_dout", 64'(dout), 64'(32'hA0 + i));
    end
    check("drain_empty", 64'(empty), 64'd1);

    // 3. Overflow
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, DW'(32'hA0 + i));
    cyc(1'b1, 1'b0, 32'hFF);
    check("ovf_count", 64'(count), 64'd4);
    check("ovf_dout",  64'(dout),  64'h0A3);
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
    check("ovf_flag", 64'(overflow), 64'd1);
`endif
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, '0);
      check("ovf_drain_dout", 64'(dout), 64'(32'hA0 + i));
    end

    // 4. Underflow
    cyc(1'b0, 1'b1, '0);
    check("unf_dout",  64'(dout),  64'h0A3);
    check("unf_count", 64'(count), 64'd0);
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
    check("unf_flag",      64'(underflow), 64'd1);
    check("ovf_flag_held", 64'(overflow),  64'd1);
`endif
    cyc(1'b1, 1'b1, 32'h55);
    check("unf_wr_count", 64'(count), 64'd1);
    check("unf_wr_dout",  64'(dout),  64'h0A3);
    cyc(1'b0, 1'b1, '0);
    check("unf_rd_dout",  64'(dout),  64'h055);

    // 5. Wrap with simultaneous access, then full + wen + read_en
    cyc(1'b1, 1'b0, 32'hB0);
    cyc(1'b1, 1'b0, 32'hB1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, DW'(32'hB2 + i));
      check("wrap_count", 64'(count), 64'd2);
      check("wrap_dout",  64'(dout),  64'(32'hB0 + i));
    end
    cyc(1'b1, 1'b0, 32'hC0);
    cyc(1'b1, 1'b0, 32'hC1);
    check("wrap_full", 64'(full), 64'd1);
    cyc(1'b1, 1'b1, 32'hEE);
    check("full_rw_count", 64'(count), 64'd3);
    check("full_rw_dout",  64'(dout),  64'h0BA);
    cyc(1'b0, 1'b1, '0); check("full_rw_d1", 64'(dout), 64'h0BB);
    cyc(1'b0, 1'b1, '0); check("full_rw_d2", 64'(dout), 64'h0C0);
    cyc(1'b0, 1'b1, '0); check("full_rw_d3", 64'(dout), 64'h0C1);
    check("full_rw_empty", 64'(empty), 64'd1);

    // 6. Merge handshake: read_en pulsed on negedge, dout captured on following negedge
    cyc(1'b1, 1'b0, 32'h11);
    cyc(1'b1, 1'b0, 32'h22);
    cyc(1'b0, 1'b1, '0);
    check("merge_d0", 64'(dout), 64'h011);
    cyc(1'b0, 1'b0, '0);
    check("merge_hold", 64'(dout), 64'h011);
    cyc(1'b0, 1'b1, '0);
    check("merge_d1", 64'(dout), 64'h022);
    check("merge_empty", 64'(empty), 64'd1);

    // Randomized phase with one mid-run reset; the compare process checks every cycle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst = 1'b0;
        cyc(1'b1, 1'b1, $urandom);
        rst = 1'b1;
      end
      cyc(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
